// File: rtl/switch_pre_ingress.sv
// Purpose: segments AXI-Stream frames into 8-word cells with first/last/pad/dest metadata for the switch core.
// Latency: an accepted word appears on the cell data strobe one cycle later; info_wr rides with word 7.
// Backpressure: i_cell_bp gates only cell starts (IDLE); pad words and mid-cell words ignore it.
// Optional: define SWITCH_PRE_STAT_EN to add stat_frames/stat_cells/stat_trunc counters.
module switch_pre_ingress #(
  parameter int CELL_WORDS = 8,
  parameter int MAX_CELLS  = 32,
  parameter int NUM_PORTS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [63:0]          s_axis_tdata,
  input  logic [7:0]           s_axis_tkeep,
  input  logic                 s_axis_tlast,
  input  logic [1:0]           s_axis_tdest,
  input  logic                 i_cell_bp,
  output logic                 i_cell_data_fifo_wr,
  output logic [63:0]          i_cell_data_fifo_din,
  output logic                 i_cell_info_wr,
  output logic                 i_cell_first,
  output logic                 i_cell_last,
  output logic [2:0]           i_pad_num_64,
  output logic [7:0]           i_last_keep,
  output logic [NUM_PORTS-1:0] i_vaild
`ifdef SWITCH_PRE_STAT_EN
  ,
  output logic [31:0]          stat_frames,
  output logic [31:0]          stat_cells,
  output logic [31:0]          stat_trunc
`endif
);

  localparam int CW = (MAX_CELLS > 1) ? $clog2(MAX_CELLS) : 1;
  localparam logic [2:0] LAST_IDX = 3'(CELL_WORDS - 1);
  localparam logic [CW-1:0] LAST_CELL = CW'(MAX_CELLS - 1);

  typedef enum logic [1:0] {IDLE, DATA, PAD, DROP} state_t;

  state_t state, state_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          first_flag, first_flag_nxt;
  logic [2:0]    pad_lat, pad_lat_nxt;
  logic [7:0]    keep_lat, keep_lat_nxt;

  logic                 wr_nxt, info_nxt, first_nxt, last_nxt;
  logic [63:0]          din_nxt;
  logic [2:0]           pad_nxt;
  logic [7:0]           keep_nxt;
  logic [NUM_PORTS-1:0] vaild_nxt;

  logic hs;

  // Input acceptance: only a cell start honours backpressure; PAD stalls the stream.
  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      IDLE:    s_axis_tready = !i_cell_bp;
      DATA:    s_axis_tready = 1'b1;
      DROP:    s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  assign hs = s_axis_tvalid && s_axis_tready;

  // Next-state and next-output computation for the segmenter.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    first_flag_nxt = first_flag;
    pad_lat_nxt    = pad_lat;
    keep_lat_nxt   = keep_lat;
    wr_nxt         = 1'b0;
    din_nxt        = i_cell_data_fifo_din;
    info_nxt       = 1'b0;
    first_nxt      = i_cell_first;
    last_nxt       = i_cell_last;
    pad_nxt        = i_pad_num_64;
    keep_nxt       = i_last_keep;
    vaild_nxt      = i_vaild;
    case (state)
      IDLE: begin
        if (hs) begin
          wr_nxt  = 1'b1;
          din_nxt = s_axis_tdata;
          idx_nxt = 3'd1;
          // Destination is taken only from the very first word of a frame.
          if (first_flag) begin
            vaild_nxt = {{(NUM_PORTS-1){1'b0}}, 1'b1} << s_axis_tdest;
          end
          if (s_axis_tlast) begin
            pad_lat_nxt  = LAST_IDX;
            keep_lat_nxt = s_axis_tkeep;
            state_nxt    = PAD;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (hs) begin
          wr_nxt  = 1'b1;
          din_nxt = s_axis_tdata;
          idx_nxt = idx + 3'd1;
          if (idx == LAST_IDX) begin
            info_nxt       = 1'b1;
            first_nxt      = first_flag;
            pad_nxt        = 3'd0;
            first_flag_nxt = 1'b0;
            state_nxt      = IDLE;
            if (s_axis_tlast) begin
              last_nxt       = 1'b1;
              keep_nxt       = s_axis_tkeep;
              first_flag_nxt = 1'b1;
              cnt_nxt        = '0;
            end else if (cnt == LAST_CELL) begin
              // Frame too long: close it here and swallow the remainder.
              last_nxt       = 1'b1;
              keep_nxt       = 8'hFF;
              first_flag_nxt = 1'b1;
              cnt_nxt        = '0;
              state_nxt      = DROP;
            end else begin
              last_nxt = 1'b0;
              keep_nxt = 8'h00;
              cnt_nxt  = cnt + CW'(1);
            end
          end else if (s_axis_tlast) begin
            pad_lat_nxt  = LAST_IDX - idx;
            keep_lat_nxt = s_axis_tkeep;
            state_nxt    = PAD;
          end
        end
      end
      PAD: begin
        wr_nxt  = 1'b1;
        din_nxt = 64'd0;
        idx_nxt = idx + 3'd1;
        if (idx == LAST_IDX) begin
          info_nxt       = 1'b1;
          first_nxt      = first_flag;
          last_nxt       = 1'b1;
          pad_nxt        = pad_lat;
          keep_nxt       = keep_lat;
          first_flag_nxt = 1'b1;
          cnt_nxt        = '0;
          state_nxt      = IDLE;
        end
      end
      DROP: begin
        if (hs && s_axis_tlast) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any partial cell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      idx                  <= 3'd0;
      cnt                  <= '0;
      first_flag           <= 1'b1;
      pad_lat              <= 3'd0;
      keep_lat             <= 8'h00;
      i_cell_data_fifo_wr  <= 1'b0;
      i_cell_data_fifo_din <= 64'd0;
      i_cell_info_wr       <= 1'b0;
      i_cell_first         <= 1'b0;
      i_cell_last          <= 1'b0;
      i_pad_num_64         <= 3'd0;
      i_last_keep          <= 8'h00;
      i_vaild              <= '0;
    end else begin
      state                <= state_nxt;
      idx                  <= idx_nxt;
      cnt                  <= cnt_nxt;
      first_flag           <= first_flag_nxt;
      pad_lat              <= pad_lat_nxt;
      keep_lat             <= keep_lat_nxt;
      i_cell_data_fifo_wr  <= wr_nxt;
      i_cell_data_fifo_din <= din_nxt;
      i_cell_info_wr       <= info_nxt;
      i_cell_first         <= first_nxt;
      i_cell_last          <= last_nxt;
      i_pad_num_64         <= pad_nxt;
      i_last_keep          <= keep_nxt;
      i_vaild              <= vaild_nxt;
    end
  end

`ifdef SWITCH_PRE_STAT_EN
  // Free-running statistics: frames closed, cells emitted, truncations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_frames <= 32'd0;
      stat_cells  <= 32'd0;
      stat_trunc  <= 32'd0;
    end else begin
      if (info_nxt) begin
        stat_cells <= stat_cells + 32'd1;
      end
      if (info_nxt && last_nxt) begin
        stat_frames <= stat_frames + 32'd1;
      end
      if (state_nxt == DROP && state != DROP) begin
        stat_trunc <= stat_trunc + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_switch_pre_ingress.sv
module tb_switch_pre_ingress;

  logic        clk = 1'b0;
  logic        reset;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic [1:0]  tdest;
  logic        bp;
  logic        wr;
  logic [63:0] din;
  logic        info_wr;
  logic        first;
  logic        last;
  logic [2:0]  pad;
  logic [7:0]  keep;
  logic [3:0]  vaild;
`ifdef SWITCH_PRE_STAT_EN
  logic [31:0] stat_frames, stat_cells, stat_trunc;
`endif

  always #5 clk = ~clk;

  switch_pre_ingress dut (
    .clk                  (clk),
    .reset                (reset),
    .s_axis_tvalid        (tvalid),
    .s_axis_tready        (tready),
    .s_axis_tdata         (tdata),
    .s_axis_tkeep         (tkeep),
    .s_axis_tlast         (tlast),
    .s_axis_tdest         (tdest),
    .i_cell_bp            (bp),
    .i_cell_data_fifo_wr  (wr),
    .i_cell_data_fifo_din (din),
    .i_cell_info_wr       (info_wr),
    .i_cell_first         (first),
    .i_cell_last          (last),
    .i_pad_num_64         (pad),
    .i_last_keep          (keep),
    .i_vaild              (vaild)
`ifdef SWITCH_PRE_STAT_EN
    ,
    .stat_frames          (stat_frames),
    .stat_cells           (stat_cells),
    .stat_trunc           (stat_trunc)
`endif
  );

  typedef struct {
    int         len;
    logic [1:0] dest;
    logic [7:0] lkeep;
    int         bp_at;
    int         exp_cells;
    logic [2:0] exp_pad;
    logic [7:0] exp_keep;
    logic [3:0] exp_vaild;
  } vec_t;

  typedef struct {
    logic       first;
    logic       last;
    logic [2:0] pad;
    logic [7:0] keep;
    logic [3:0] vaild;
    int         nwords;
  } cell_t;

  cell_t       cells_q[$];
  logic [63:0] data_q[$];
  logic [63:0] cur_q[$];
  int          wr_count = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cell monitor: collects written words and commits them on each info strobe.
  always @(posedge clk) begin : mon
    cell_t c;
    #1;
    if (!reset) begin
      if (wr) begin
        cur_q.push_back(din);
        wr_count++;
      end
      if (info_wr) begin
        c.first  = first;
        c.last   = last;
        c.pad    = pad;
        c.keep   = keep;
        c.vaild  = vaild;
        c.nwords = cur_q.size();
        foreach (cur_q[k]) data_q.push_back(cur_q[k]);
        cur_q.delete();
        cells_q.push_back(c);
      end
    end
  end

  function automatic logic [63:0] word_of(input logic [7:0] fid, input int i);
    return {fid, 24'h0, 32'(i)};
  endfunction

  // Drives one frame; tdest is deliberately corrupted after word 0.
  task automatic send_frame(input int len, input logic [1:0] dest, input logic [7:0] lkeep,
                            input logic [7:0] fid, input int bp_at, input int stop);
    int  i = 0;
    int  guard = 0;
    int  snap;
    logic hs;
    while (i < len && i < stop) begin
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = word_of(fid, i);
      tlast  = (i == len - 1);
      tkeep  = (i == len - 1) ? lkeep : 8'hFF;
      tdest  = (i == 0) ? dest : ~dest;
      if (i == bp_at && guard >= 0) begin
        bp   = 1'b1;
        snap = wr_count;
        for (int k = 0; k < 10; k++) begin
          #1;
          chk("bp_tready_low", 64'(tready), 64'd0);
          @(negedge clk);
        end
        chk("bp_no_wr", 64'(wr_count), 64'(snap));
        bp = 1'b0;
        #1;
        chk("bp_resume_tready", 64'(tready), 64'd1);
        guard = -100000;
      end else begin
        #1;
      end
      hs = tready;
      @(posedge clk);
      if (hs) i++;
      guard++;
      if (guard > 5000) begin
        chk("send_timeout", 64'(i), 64'(len));
        break;
      end
    end
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  // Compares collected cells against the frame's expected segmentation.
  task automatic check_frame(input vec_t v, input logic [7:0] fid);
    int    g = 0;
    int    lim;
    int    w;
    cell_t c;
    logic [63:0] exp_w;
    while (cells_q.size() < v.exp_cells && g < 300) begin
      @(posedge clk);
      g++;
    end
    repeat (12) @(posedge clk);
    #2;
    chk("cell_count", 64'(cells_q.size()), 64'(v.exp_cells));
    lim = (v.len < 256) ? v.len : 256;
    for (int ci = 0; ci < v.exp_cells && cells_q.size() > 0; ci++) begin
      c = cells_q.pop_front();
      chk("cell_first", 64'(c.first), 64'(ci == 0));
      chk("cell_last", 64'(c.last), 64'(ci == v.exp_cells - 1));
      chk("cell_vaild", 64'(c.vaild), 64'(v.exp_vaild));
      chk("cell_nwords", 64'(c.nwords), 64'd8);
      if (ci == v.exp_cells - 1) begin
        chk("cell_pad", 64'(c.pad), 64'(v.exp_pad));
        chk("cell_keep", 64'(c.keep), 64'(v.exp_keep));
      end else begin
        chk("cell_pad_mid", 64'(c.pad), 64'd0);
      end
      for (int j = 0; j < c.nwords && data_q.size() > 0; j++) begin
        w = 8 * ci + j;
        exp_w = (w < lim) ? word_of(fid, w) : 64'd0;
        chk("cell_data", data_q.pop_front(), exp_w);
      end
    end
    cells_q.delete();
    data_q.delete();
  endtask

  vec_t vecs[6];
  vec_t v1;
  vec_t v8;

  initial begin
    reset  = 1'b1;
    tvalid = 1'b0;
    tdata  = 64'd0;
    tkeep  = 8'h00;
    tlast  = 1'b0;
    tdest  = 2'd0;
    bp     = 1'b0;

    //            len  dest  lkeep bp_at cells pad keep   vaild
    vecs[0] = '{  8,   2'd2, 8'hFF, -1,   1,   3'd0, 8'hFF, 4'b0100};
    vecs[1] = '{ 11,   2'd1, 8'h0F, -1,   2,   3'd5, 8'h0F, 4'b0010};
    vecs[2] = '{300,   2'd3, 8'h03, -1,  32,   3'd0, 8'hFF, 4'b1000};
    vecs[3] = '{ 16,   2'd0, 8'hFF,  8,   2,   3'd0, 8'hFF, 4'b0001};
    vecs[4] = '{256,   2'd1, 8'h3F, -1,  32,   3'd0, 8'h3F, 4'b0010};
    vecs[5] = '{ 15,   2'd2, 8'h7F, -1,   2,   3'd1, 8'h7F, 4'b0100};
    v1      = '{  1,   2'd0, 8'h01, -1,   1,   3'd7, 8'h01, 4'b0001};
    v8      = '{  8,   2'd3, 8'h1F, -1,   1,   3'd0, 8'h1F, 4'b1000};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_din", din, 64'd0);
    chk("rst_info", 64'(info_wr), 64'd0);
    chk("rst_meta", 64'({first, last, pad, keep}), 64'd0);
    chk("rst_vaild", 64'(vaild), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_tready", 64'(tready), 64'd1);

    for (int n = 0; n < 6; n++) begin
      send_frame(vecs[n].len, vecs[n].dest, vecs[n].lkeep, 8'(n + 1), vecs[n].bp_at, 1 << 20);
      check_frame(vecs[n], 8'(n + 1));
    end

    // Single-word frame: the pad phase must hold off the stream for 7 cycles.
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = word_of(8'h40, 0);
    tlast  = 1'b1;
    tkeep  = 8'h01;
    tdest  = 2'd0;
    #1;
    chk("one_word_tready", 64'(tready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("pad_tready_low", 64'(tready), 64'd0);
      @(negedge clk);
    end
    #1;
    chk("pad_tready_back", 64'(tready), 64'd1);
    check_frame(v1, 8'h40);

    // Reset mid-frame at word 3 of the second cell, then a clean frame.
    send_frame(16, 2'd1, 8'hFF, 8'h50, -1, 11);
    reset = 1'b1;
    #1;
    chk("midrst_wr", 64'(wr), 64'd0);
    chk("midrst_din", din, 64'd0);
    chk("midrst_vaild", 64'(vaild), 64'd0);
    chk("midrst_meta", 64'({info_wr, first, last, pad, keep}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cells_q.delete();
    data_q.delete();
    cur_q.delete();
    send_frame(v8.len, v8.dest, v8.lkeep, 8'h60, -1, 1 << 20);
    check_frame(v8, 8'h60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_pre_ingress.md
Name: switch_pre_ingress

Overview:
Ingress segmenter for one switch port. It accepts Ethernet frames on a 64-bit AXI-Stream slave and cuts them into fixed 8-word (64-byte) cells for the shared switch core. Each cell carries first/last/pad/destination metadata, and cell starts are gated by the core's per-port backpressure. It is the transmit-side counterpart of the per-port post/egress path; one instance is used per port.

Parameters:
CELL_WORDS, 8, 64-bit words per cell; fixed by the switch core, only 8 supported
MAX_CELLS, 32, maximum cells per frame (2048 B); longer frames are truncated
NUM_PORTS, 4, width of the one-hot destination vector

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
s_axis_tvalid  in  1  frame word valid
s_axis_tready  out  1  frame word accepted
s_axis_tdata  in  64  frame data
s_axis_tkeep  in  8  byte enables; meaningful only on the tlast word
s_axis_tlast  in  1  last word of frame
s_axis_tdest  in  2  destination port index, sampled on the first word of a frame
i_cell_bp  in  1  core backpressure; 1 = do not start a new cell
i_cell_data_fifo_wr  out  1  cell data word write strobe
i_cell_data_fifo_din  out  64  cell data word
i_cell_info_wr  out  1  cell metadata strobe; coincides with word 7 of each cell
i_cell_first  out  1  cell is the first cell of its frame
i_cell_last  out  1  cell is the last cell of its frame
i_pad_num_64  out  3  number of zero pad words in the cell (0..7)
i_last_keep  out  8  tkeep of the final frame word; valid when i_cell_last=1
i_vaild  out  NUM_PORTS  one-hot destination

Behaviour:
- Reset: all outputs 0, state IDLE, word index 0, cell count 0, first-flag set. A reset in mid-frame abandons the partial cell. The core discards any cell without info_wr.
- s_axis_tready is combinational from state and i_cell_bp. All other outputs are registered.
- Latency: an accepted word appears on din/wr in the next cycle. info_wr rides the same cycle as the wr of word 7.
- IDLE (cell boundary): tready = !i_cell_bp.
  - On handshake: write word 0 and set idx=1.
  - If this is the first cell of the frame, latch i_vaild = 1<<tdest.
  - If tlast, go to PAD; otherwise go to DATA.
- DATA: tready=1. Each handshake writes word idx and increments idx. Gaps in tvalid are allowed mid-cell.
  - tlast at idx<7: go to PAD.
  - idx==7 completes the cell: info_wr=1, pad=0.
    - If tlast: last=1, keep=tkeep, go to IDLE.
    - Else if cell count == MAX_CELLS-1: last=1, keep=8'hFF, go to DROP.
    - Else: go to IDLE.
- PAD: tready=0. Write one zero word per cycle, ignoring i_cell_bp, until word 7.
  - On word 7: info_wr=1, last=1, pad = 7 - idx of the tlast word, keep = latched tkeep.
  - Then go to IDLE.
- DROP: tready=1. Discard words without writing them. The tlast handshake returns to IDLE.
- i_cell_first: 1 on the first cell after reset or after a frame end, 0 on the others. Clears after that cell's info_wr.
- Cell count resets at frame end. Arithmetic is unsigned. idx is 3 bits and wraps 7→0 only at a cell end.
- tlast on exactly word 7: pad=0, no PAD state.
- tlast on cell MAX_CELLS: normal end, not truncation.
- i_cell_bp asserted mid-cell has no effect until the next IDLE.
- i_vaild holds until the next frame's first word.

Optional Feature:
SWITCH_PRE_STAT_EN
- Defined: adds 32-bit outputs stat_frames, stat_cells and stat_trunc.
  - They count completed frames, info_wr strobes and DROP entries respectively.
  - They wrap at 2^32, clear on reset, and are registered.
- Undefined: no ports, no counters, no logic.

Test Plan:
- 8-word frame, tdest=2, bp=0: one cell with first=1, last=1, pad=0, vaild=4'b0100, eight wr pulses, info_wr on the 8th.
- 11-word frame, tkeep=8'h0F on the last word: two cells; cell 2 has words 8-10 then 5 zero words, pad=5, keep=8'h0F, first=0, last=1.
- 1-word frame: one cell, pad=7, tready low for 7 cycles after the handshake.
- i_cell_bp=1 at a cell boundary of a 16-word frame for 10 cycles: tready=0 throughout, no wr; resumes the cycle after bp falls, and data is unchanged and ordered.
- 300-word frame with MAX_CELLS=32: 32 cells, the last with last=1 and keep=8'hFF; 44 words dropped. The next frame starts with first=1.
- Reset asserted at word 3 of cell 2: outputs 0 immediately. A subsequent 8-word frame produces a clean single cell with first=1.
